// File: rtl/request_queue_pkg.sv
// Shared types and size defaults for the request queue: parser op format, stored request, queue entry.
package request_queue_pkg;

    localparam int QUEUE_DEPTH   = 16;
    localparam int AGE_WIDTH     = 8;
    localparam int ADDRESS_WIDTH = 34;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } parsed_op_t;

    typedef logic [AGE_WIDTH-1:0] age_t;

    typedef struct packed {
        parsed_op_t               opcode;
        logic [ADDRESS_WIDTH-1:0] address;
        logic [31:0]              time_cpu;
        logic                     op_ready_s;
    } parser_out_struct_t;

    typedef struct packed {
        parsed_op_t               opcode;
        logic [ADDRESS_WIDTH-1:0] address;
        logic [31:0]              time_cpu;
    } request_t;

    typedef struct packed {
        parsed_op_t               opcode;
        logic [ADDRESS_WIDTH-1:0] address;
        logic [31:0]              time_cpu;
        age_t                     age;
    } queue_entry_t;

    function automatic logic is_real_op(parsed_op_t op);
        return op != NOP;
    endfunction

endpackage

// File: rtl/request_fifo.sv
// Circular request storage with per-entry saturating ages; head/count/full/empty decode from registers.
// Push is accepted when not full or when a pop lands the same cycle; a pop while empty is ignored.
module request_fifo
    import request_queue_pkg::*;
#(
    parameter int DEPTH     = QUEUE_DEPTH,
    parameter int AGE_WIDTH = request_queue_pkg::AGE_WIDTH,
    localparam int PW       = $clog2(DEPTH),
    localparam int CW       = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  request_t      push_data,
    input  logic          pop,
    output queue_entry_t  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam logic [CW-1:0]        FULL_COUNT = CW'(DEPTH);
    localparam logic [AGE_WIDTH-1:0] AGE_MAX    = '1;

    request_t             mem   [DEPTH];
    logic [AGE_WIDTH-1:0] age_q [DEPTH];
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        head_idx;
    logic [PW-1:0]        offs;
    logic [DEPTH-1:0]     age_inc;
    logic                 pop_eff;
    logic                 push_eff;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);

    // While empty, point at the slot just popped so head keeps showing its last value.
    assign head_idx = empty ? rd_ptr - PW'(1) : rd_ptr;

    always_comb begin
        head.opcode   = mem[head_idx].opcode;
        head.address  = mem[head_idx].address;
        head.time_cpu = mem[head_idx].time_cpu;
        head.age      = age_t'(age_q[head_idx]);
    end

    // Only entries that stay resident across this edge keep ageing.
    always_comb begin
        offs    = '0;
        age_inc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs       = PW'(i) - rd_ptr;
            age_inc[i] = ({1'b0, offs} < count) && !(pop_eff && offs == '0)
                         && (age_q[i] != AGE_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i]   <= '0;
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (age_inc[i]) begin
                    age_q[i] <= age_q[i] + AGE_WIDTH'(1);
                end
            end
            if (push_eff) begin
                mem[wr_ptr]   <= push_data;
                age_q[wr_ptr] <= '0;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_eff, pop_eff})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/request_queue.sv
// Holds one parsed op until cpu_time reaches its timestamp, then queues it for the scheduler (head 2 cycles after op_ready_s).
// Parser is throttled by pending_request/queue_full; REQUEST_QUEUE_TIME_SKIP_EN jumps cpu_time over idle gaps.
module request_queue
    import request_queue_pkg::*;
#(
    parameter int DEPTH     = QUEUE_DEPTH,
    parameter int AGE_WIDTH = request_queue_pkg::AGE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  parser_out_struct_t     in,
    output logic                   queue_full,
    output logic                   pending_request,
    output logic                   head_valid,
    output queue_entry_t           head,
    input  logic                   head_pop,
    output logic [$clog2(DEPTH):0] count,
    output logic [31:0]            cpu_time
);

    logic     phase;
    logic     hold_vld;
    request_t hold;
    logic     fifo_full;
    logic     fifo_empty;
    logic     capture;
    logic     time_met;
    logic     insert;

    assign capture  = in.op_ready_s && is_real_op(in.opcode) && !hold_vld;
    assign time_met = (hold.time_cpu <= cpu_time);
    // A held op can enter a full queue when the scheduler frees the head slot this same cycle.
    assign insert   = hold_vld && time_met && (!fifo_full || (head_pop && !fifo_empty));

    assign queue_full      = fifo_full;
    assign pending_request = hold_vld;
    assign head_valid      = !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= 1'b0;
            cpu_time <= '0;
            hold_vld <= 1'b0;
            hold     <= '0;
        end else begin
`ifdef REQUEST_QUEUE_TIME_SKIP_EN
            if (hold_vld && fifo_empty && !time_met) begin
                cpu_time <= hold.time_cpu;
                phase    <= 1'b0;
            end else begin
                phase <= ~phase;
                if (phase) begin
                    cpu_time <= cpu_time + 32'd1;
                end
            end
`else
            phase <= ~phase;
            if (phase) begin
                cpu_time <= cpu_time + 32'd1;
            end
`endif
            if (insert) begin
                hold_vld <= 1'b0;
            end else if (capture) begin
                hold_vld <= 1'b1;
                hold     <= '{opcode: in.opcode, address: in.address, time_cpu: in.time_cpu};
            end
        end
    end

    request_fifo #(
        .DEPTH     (DEPTH),
        .AGE_WIDTH (AGE_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (insert),
        .push_data (hold),
        .pop       (head_pop),
        .head      (head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_request_queue.sv
// Bench for request_queue: randomized ops against a queue-based reference model plus a pop-order scoreboard.
module tb_request_queue;
    import request_queue_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AMAX  = (1 << AW) - 1;

    typedef struct {
        parsed_op_t  op;
        logic [33:0] addr;
        logic [31:0] t;
        longint      ins;
    } exp_t;

    logic               clk      = 1'b0;
    logic               rst_n    = 1'b0;
    parser_out_struct_t in_s     = '0;
    logic               head_pop = 1'b0;
    logic               queue_full;
    logic               pending_request;
    logic               head_valid;
    queue_entry_t       head;
    logic [4:0]         count;
    logic [31:0]        cpu_time;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t        mq[$];
    exp_t        sb[$];
    exp_t        m_hold;
    logic        m_hold_vld = 1'b0;
    longint      cyc        = 0;
    longint      base_cyc   = 0;
    logic [31:0] base_t     = '0;
    logic [33:0] fill_addr [17];

    request_queue #(.DEPTH(DEPTH), .AGE_WIDTH(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in              (in_s),
        .queue_full      (queue_full),
        .pending_request (pending_request),
        .head_valid      (head_valid),
        .head            (head),
        .head_pop        (head_pop),
        .count           (count),
        .cpu_time        (cpu_time)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // CPU time is half the clocks since reset or since the last time jump.
    function automatic logic [31:0] model_cpu();
        return base_t + 32'((cyc - base_cyc) / 2);
    endfunction

    task automatic model_step();
        logic [31:0] now;
        logic        pop_eff, ins, cap, skip;
        now = model_cpu();
        if (!rst_n) begin
            mq.delete();
            sb.delete();
            m_hold_vld = 1'b0;
            cyc++;
            base_cyc = cyc;
            base_t   = '0;
            return;
        end
        pop_eff = head_pop && (mq.size() > 0);
        ins     = m_hold_vld && (m_hold.t <= now) && ((mq.size() < DEPTH) || pop_eff);
        cap     = in_s.op_ready_s && (in_s.opcode != NOP) && !m_hold_vld;
`ifdef REQUEST_QUEUE_TIME_SKIP_EN
        skip    = (mq.size() == 0) && m_hold_vld && (m_hold.t > now);
`else
        skip    = 1'b0;
`endif
        cyc++;
        if (skip) begin
            base_t   = m_hold.t;
            base_cyc = cyc;
        end
        if (pop_eff) void'(mq.pop_front());
        if (ins) begin
            m_hold.ins = cyc;
            mq.push_back(m_hold);
            sb.push_back(m_hold);
            m_hold_vld = 1'b0;
        end
        if (cap) begin
            m_hold.op   = in_s.opcode;
            m_hold.addr = in_s.address;
            m_hold.t    = in_s.time_cpu;
            m_hold_vld  = 1'b1;
        end
    endtask

    task automatic monitor_step();
        exp_t   e;
        longint age;
        check("count", count, mq.size());
        check("queue_full", queue_full, mq.size() == DEPTH);
        check("pending_request", pending_request, m_hold_vld);
        check("head_valid", head_valid, mq.size() != 0);
        check("cpu_time", cpu_time, model_cpu());
        if (head_valid && mq.size() != 0) begin
            age = cyc - mq[0].ins;
            if (age > AMAX) age = AMAX;
            check("head_opcode", head.opcode, mq[0].op);
            check("head_address", head.address, mq[0].addr);
            check("head_time", head.time_cpu, mq[0].t);
            check("head_age", head.age, age);
        end
        if (head_valid && head_pop) begin
            check("sb_has_entry", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pop_opcode", head.opcode, e.op);
                check("pop_address", head.address, e.addr);
                check("pop_time", head.time_cpu, e.t);
            end
        end
    endtask

    always @(posedge clk) model_step();
    always @(negedge clk) if (rst_n) monitor_step();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic parsed_op_t rand_op();
        return ($urandom_range(0, 1) == 0) ? READ : WRITE;
    endfunction

    function automatic logic [33:0] rand_addr();
        return 34'({$urandom(), $urandom()});
    endfunction

    task automatic drive_op(input parsed_op_t op, input logic [33:0] a, input logic [31:0] t);
        in_s.opcode     = op;
        in_s.address    = a;
        in_s.time_cpu   = t;
        in_s.op_ready_s = 1'b1;
        tick();
        in_s.op_ready_s = 1'b0;
    endtask

    task automatic push_op(input parsed_op_t op, input logic [33:0] a, input logic [31:0] t);
        for (int i = 0; i < 100 && pending_request; i++) tick();
        check("push_slot_free", pending_request, 1'b0);
        drive_op(op, a, t);
    endtask

    task automatic wait_head(input string name);
        for (int i = 0; i < 100 && !head_valid; i++) tick();
        check(name, head_valid, 1'b1);
    endtask

    task automatic drain();
        head_pop = 1'b1;
        for (int i = 0; i < 300 && (head_valid || pending_request); i++) tick();
        head_pop = 1'b0;
        check("drain_empty", head_valid || pending_request, 1'b0);
    endtask

    initial begin
        logic [31:0] tt;
        parsed_op_t  op;

        #12;
        check("rst_queue_full", queue_full, 1'b0);
        check("rst_pending", pending_request, 1'b0);
        check("rst_head_valid", head_valid, 1'b0);
        check("rst_count", count, 0);
        check("rst_cpu_time", cpu_time, 0);
        check("rst_head_opcode", head.opcode, NOP);
        check("rst_head_address", head.address, 0);
        check("rst_head_time", head.time_cpu, 0);
        check("rst_head_age", head.age, 0);
        #16 rst_n = 1'b1;

        // First op: pending next cycle, at head the cycle after, then ageing.
        tick();
        tick();
        drive_op(READ, 34'h1_2345_6780, 32'd0);
        check("lat_pending_n1", pending_request, 1'b1);
        check("lat_head_valid_n1", head_valid, 1'b0);
        tick();
        check("lat_head_valid_n2", head_valid, 1'b1);
        check("lat_pending_n2", pending_request, 1'b0);
        check("lat_head_opcode", head.opcode, READ);
        check("lat_head_address", head.address, 34'h1_2345_6780);
        check("lat_age0", head.age, 0);
        tick();
        check("lat_age1", head.age, 1);
        head_pop = 1'b1;
        tick();
        head_pop = 1'b0;
        check("pop_to_empty", head_valid, 1'b0);
        check("empty_head_holds", head.address, 34'h1_2345_6780);

        drive_op(NOP, rand_addr(), 32'd0);
        check("nop_ignored", pending_request, 1'b0);

        // Op stamped in the future waits for cpu_time (or triggers the time jump).
        tt = model_cpu() + 32'd8;
        push_op(rand_op(), rand_addr(), tt);
        wait_head("future_inserted");
        check("future_time_reached", cpu_time >= tt, 1'b1);
        drain();

        // Fill to 16, hold a 17th, then pop once while full.
        for (int k = 0; k < 17; k++) begin
            fill_addr[k] = rand_addr();
            push_op(rand_op(), fill_addr[k], 32'd0);
        end
        tick();
        tick();
        check("fill_full", queue_full, 1'b1);
        check("fill_count", count, 16);
        check("fill_pending", pending_request, 1'b1);
        drive_op(rand_op(), rand_addr(), 32'd0);
        check("held_still_pending", pending_request, 1'b1);
        head_pop = 1'b1;
        tick();
        head_pop = 1'b0;
        check("full_pop_count", count, 16);
        check("full_pop_full", queue_full, 1'b1);
        check("full_pop_pending", pending_request, 1'b0);
        check("full_pop_head", head.address, fill_addr[1]);
        drain();

        // Alternating push/pop across pointer wrap.
        for (int k = 0; k < 40; k++) begin
            push_op(rand_op(), rand_addr(), model_cpu());
            wait_head("wrap_head");
            check("wrap_count_le1", count <= 1, 1'b1);
            head_pop = 1'b1;
            tick();
            head_pop = 1'b0;
        end

        push_op(rand_op(), rand_addr(), 32'd0);
        wait_head("age_head");
        repeat (20) tick();
        check("age_saturated", head.age, AMAX);
        drain();

        // Random traffic, including NOPs and ops offered while the hold is busy.
        for (int c = 0; c < 1500; c++) begin
            head_pop = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 1) == 1) begin
                op = ($urandom_range(0, 9) == 0) ? NOP : rand_op();
                drive_op(op, rand_addr(), model_cpu() + 32'($urandom_range(0, 6)));
            end else begin
                tick();
            end
        end
        head_pop = 1'b0;
        drain();

        // Asynchronous reset with five entries resident.
        for (int k = 0; k < 5; k++) push_op(rand_op(), rand_addr(), 32'd0);
        tick();
        check("pre_reset_count", count, 5);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_head_valid", head_valid, 1'b0);
        check("async_rst_pending", pending_request, 1'b0);
        check("async_rst_cpu_time", cpu_time, 0);
        check("async_rst_full", queue_full, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        push_op(READ, rand_addr(), 32'd0);
        wait_head("post_reset_head");
        drain();
        check("sb_empty_end", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/request_queue.md
# request_queue

Request queue that sits directly downstream of the trace parser in the memory-controller model. It captures each parsed op into a one-entry hold register and keeps a CPU-time counter. Each op is released into a circular queue of pending requests once its CPU timestamp is reached. It returns `queue_full` and `pending_request` to the parser as flow control, and presents the oldest request, with its age, to the DRAM scheduler through a valid/pop handshake.

## Interface
- `DEPTH`, 16: queue entries; power of two, ≥ 2.
- `AGE_WIDTH`, 8: per-entry age counter width.
- `clk` in 1: DRAM-rate clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in` in `parser_out_struct_t`: parser output (`opcode`, `address[ADDRESS_WIDTH-1:0]`, `time_cpu[31:0]`, `op_ready_s`).
- `queue_full` out 1: `count == DEPTH`.
- `pending_request` out 1: the hold register holds an op not yet inserted.
- `head_valid` out 1: the queue is non-empty.
- `head` out `queue_entry_t`: oldest entry (`opcode`, `address`, `time_cpu`, `age`).
- `head_pop` in 1: the scheduler consumes the head; effective only when `head_valid`.
- `count` out $clog2(DEPTH)+1: occupancy.
- `cpu_time` out 32: current CPU time.

## Operation
- Reset values of outputs: `queue_full`=0, `pending_request`=0, `head_valid`=0, `count`=0, `cpu_time`=0. `head` is all-zero with `opcode`=NOP.
- Reset also clears the internal state: pointers=0, `phase`=0, hold register invalid. Reset asserted mid-operation discards all entries and the held op immediately.
- CPU time:
  - `phase` toggles every `clk`.
  - `cpu_time` increments on edges where `phase`==1, so it advances at half the `clk` rate.
  - It wraps at 2^32 without special handling.
- Capture:
  - Capture happens when `in.op_ready_s`=1, `in.opcode`!=NOP and the hold register is empty.
  - The op is latched and the hold register becomes valid, so `pending_request`=1 from the next cycle.
  - `op_ready_s` while the hold register is occupied is ignored.
- Insert:
  - Insert happens when the hold register is valid, `hold.time_cpu <= cpu_time`, and either `count<DEPTH` or a pop happens in the same cycle.
  - The entry is written at `wr_ptr` with `age`=0, `wr_ptr` increments mod DEPTH, and the hold register is cleared.
  - Capture and insert never occur for the same op in the same cycle.
- Pop: when `head_valid && head_pop`, `rd_ptr` increments mod DEPTH.
- Simultaneous push and pop:
  - `count` is unchanged.
  - This is legal even when full.
  - When the queue is empty, a push and a pop in the same cycle cannot happen, because `head_valid`=0.
- Ages:
  - Every valid entry's `age` increments each `clk`, saturating at 2^AGE_WIDTH−1.
  - An entry pushed this cycle starts at 0.
- Empty:
  - `head_valid`=0 and `head` holds its last value.
  - A pop attempt has no effect.

## Timing
- Parser `op_ready_s` in cycle N → `pending_request`=1 in N+1.
- If the time is already met and the queue is not full, the op is inserted at the end of N+1. Then `pending_request`=0 and `head_valid`=1 (if the queue was empty) in N+2.
- `queue_full`, `pending_request`, `head_valid`, `head` and `count` are registered or decoded directly from registers; none depends combinationally on `in` or `head_pop`.
- A pop in cycle M while full makes `queue_full`=0 in M+1. A held op waiting on full is inserted in cycle M itself.

## Configuration
- `REQUEST_QUEUE_TIME_SKIP_EN` defined:
  - Applies when `count`==0, the hold register is valid and `hold.time_cpu > cpu_time`.
  - Then `cpu_time <= hold.time_cpu` and `phase <= 0`. The op is inserted the following cycle.
  - This removes idle stretches between sparse trace entries.
- Undefined: `cpu_time` only counts; the op waits for real time to elapse.

## Structure
- Into `global_defs`:
  - `queue_entry_t` (`opcode` as `parsed_op_t`, `address`, `time_cpu`, `age`).
  - `QUEUE_DEPTH`=16 and `AGE_WIDTH`=8 constants, used as parameter defaults.
- Sub-module `request_fifo`:
  - Circular storage, pointers, count and per-entry ages.
  - Ports: push/push_data, pop, head, count, full, empty.
- `request_queue` owns the hold register, `phase`/`cpu_time` and the insert decision.

## Test plan
- Reset mid-stream with 5 entries queued: assert `rst_n`=0 asynchronously.
  - Required: `count`=0, `head_valid`=0, `pending_request`=0 and `cpu_time`=0 before the next `clk` edge.
- Single op with `time_cpu`=0, opcode READ, address 0x1_2345_6780, `op_ready_s` in cycle 3.
  - Required: `pending_request`=1 in cycle 4, `head_valid`=1 with a matching `head` in cycle 5, `age`=1 in cycle 6.
- Op with `time_cpu`=10 arriving at `cpu_time`=2, macro undefined.
  - Required: inserted on the edge where `cpu_time` reaches 10.
  - With the macro defined, `cpu_time` jumps to 10 one cycle after capture and the op is inserted the next cycle.
- 17 ops at `time_cpu`=0 with no pops.
  - Required: `queue_full`=1 after 16 entries, and the 17th is held with `pending_request`=1.
  - One pop while full must insert the 17th in the same cycle: `count` stays 16 and the head becomes entry 2.
- Wrap-around: push and pop 40 ops alternately.
  - Required: FIFO order preserved across pointer wrap, and `count` never exceeds 1.
- Age saturation with AGE_WIDTH=4: hold one entry for 20 cycles.
  - Required: `age` stays at 15.
- `op_ready_s` with opcode NOP is ignored; `op_ready_s` while the hold register is full leaves the held op unchanged.
